// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared types for the chess move reporter
package chess_pkg;

    typedef logic [5:0] square_t;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } side_e;

    typedef enum logic [1:0] {
        REJ_NONE      = 2'b00,
        REJ_ILLEGAL   = 2'b01,
        REJ_TIMEOUT   = 2'b10,
        REJ_MALFORMED = 2'b11
    } rej_e;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REPORT,
        DONE
    } state_e;

    function automatic logic is_malformed(square_t from_sq, square_t to_sq);
        return from_sq == to_sq;
    endfunction

endpackage

// File: rtl/chess_timeout_ctr.sv
// rtl/chess_timeout_ctr.sv - checker response watchdog; expired once count reaches TIMEOUT_CYCLES-1
module chess_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/chess_move_reporter.sv
// rtl/chess_move_reporter.sv - forwards player moves to the legality checker and reports verdicts
module chess_move_reporter
    import chess_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MOVE_CNT_W     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [5:0]            req_from,
    input  logic [5:0]            req_to,
    output logic                  req_ready,
    output logic                  chk_valid,
    output logic [5:0]            chk_from,
    output logic [5:0]            chk_to,
    output logic                  chk_side,
    input  logic                  chk_done,
    input  logic                  chk_legal,
    input  logic                  chk_mate,
    input  logic                  chk_stale,
    output logic                  WM,
    output logic                  WC,
    output logic                  BM,
    output logic                  BC,
    output logic                  SM,
    output logic                  rej,
    output logic [1:0]            rej_code,
    output logic                  side,
    output logic [MOVE_CNT_W-1:0] move_count
);
    state_e state;
    side_e  side_q;
    rej_e   rej_q;
    logic   v_legal, v_mate, v_stale;
    logic   tmo_expired;

    chess_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != CHECK),
        .enable  (state == CHECK),
        .expired (tmo_expired)
    );

    assign req_ready = (state == IDLE);
    assign rej_code  = rej_q;
    assign side      = side_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            side_q     <= WHITE;
            rej_q      <= REJ_NONE;
            move_count <= '0;
            chk_valid  <= 1'b0;
            chk_from   <= '0;
            chk_to     <= '0;
            chk_side   <= 1'b0;
            v_legal    <= 1'b0;
            v_mate     <= 1'b0;
            v_stale    <= 1'b0;
            WM         <= 1'b0;
            WC         <= 1'b0;
            BM         <= 1'b0;
            BC         <= 1'b0;
            SM         <= 1'b0;
            rej        <= 1'b0;
        end else begin
            WM  <= 1'b0;
            WC  <= 1'b0;
            BM  <= 1'b0;
            BC  <= 1'b0;
            SM  <= 1'b0;
            rej <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // malformed moves are bounced here and never reach the checker
                        if (is_malformed(req_from, req_to)) begin
                            rej   <= 1'b1;
                            rej_q <= REJ_MALFORMED;
                        end else begin
                            chk_from  <= req_from;
                            chk_to    <= req_to;
                            chk_side  <= side_q;
                            chk_valid <= 1'b1;
                            state     <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (chk_done) begin
                        v_legal   <= chk_legal;
                        v_mate    <= chk_mate;
                        v_stale   <= chk_stale;
                        chk_valid <= 1'b0;
                        state     <= REPORT;
                    end else if (tmo_expired) begin
                        rej       <= 1'b1;
                        rej_q     <= REJ_TIMEOUT;
                        chk_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                REPORT: begin
                    if (!v_legal) begin
                        rej   <= 1'b1;
                        rej_q <= REJ_ILLEGAL;
                        state <= IDLE;
                    end else begin
                        if (move_count != '1) begin
                            move_count <= move_count + MOVE_CNT_W'(1);
                        end
                        // mate outranks stalemate; both end the game
                        if (v_mate) begin
                            if (side_q == WHITE) begin
                                WM <= 1'b1;
                                WC <= 1'b1;
                            end else begin
                                BM <= 1'b1;
                                BC <= 1'b1;
                            end
                            state <= DONE;
                        end else if (v_stale) begin
                            SM    <= 1'b1;
                            state <= DONE;
                        end else begin
                            if (side_q == WHITE) begin
                                WM <= 1'b1;
                            end else begin
                                BM <= 1'b1;
                            end
                            side_q <= (side_q == WHITE) ? BLACK : WHITE;
                            state  <= IDLE;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chess_move_reporter.sv
// tb/tb_chess_move_reporter.sv - self-checking bench for chess_move_reporter
module tb_chess_move_reporter;
    localparam int MAXC = 16384;
    localparam int TMO  = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [5:0] req_from = '0, req_to = '0;
    logic       chk_done = 1'b0, chk_legal = 1'b0, chk_mate = 1'b0, chk_stale = 1'b0;
    logic       req_ready, chk_valid, chk_side;
    logic [5:0] chk_from, chk_to;
    logic       WM, WC, BM, BC, SM, rej, side;
    logic [1:0] rej_code;
    logic [9:0] move_count;

    chess_move_reporter #(.TIMEOUT_CYCLES(TMO), .MOVE_CNT_W(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_from(req_from), .req_to(req_to), .req_ready(req_ready),
        .chk_valid(chk_valid), .chk_from(chk_from), .chk_to(chk_to), .chk_side(chk_side),
        .chk_done(chk_done), .chk_legal(chk_legal), .chk_mate(chk_mate), .chk_stale(chk_stale),
        .WM(WM), .WC(WC), .BM(BM), .BC(BC), .SM(SM), .rej(rej), .rej_code(rej_code),
        .side(side), .move_count(move_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int n_wm = 0, n_wc = 0, n_bm = 0, n_bc = 0, n_sm = 0, n_rej = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: game-level bookkeeping with outcomes scheduled by cycle number
    logic [5:0] exp_p [MAXC];
    int   cyc = 0, ready_from = 0, over_from = 2 * MAXC, start = 0, pend_cyc = 0;
    bit   run = 0, inflight = 0, pend = 0;
    logic m_side = 0, p_side = 0, m_cside = 0;
    logic [9:0] m_count = 0, p_count = 0;
    logic [1:0] m_code = 0, p_code = 0;
    logic [5:0] m_from = 0, m_to = 0;

    initial for (int k = 0; k < MAXC; k++) exp_p[k] = 6'b0;

    function automatic bit exp_ready(input int c);
        return !inflight && c >= ready_from && c < over_from;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            run = 1; inflight = 0; pend = 0;
            m_side = 0; m_count = 0; m_code = 0;
            ready_from = cyc + 1; over_from = 2 * MAXC;
            for (int k = 1; k <= 3; k++) exp_p[cyc + k] = 6'b0;
        end else if (run) begin
            if (pend && cyc + 1 == pend_cyc) begin
                m_side = p_side; m_count = p_count; m_code = p_code; pend = 0;
            end
            if (exp_ready(cyc) && req_valid) begin
                if (req_from == req_to) begin
                    exp_p[cyc + 1] = 6'b000001; m_code = 2'b11;
                end else begin
                    inflight = 1; start = cyc + 1;
                    m_from = req_from; m_to = req_to; m_cside = m_side;
                end
            end else if (inflight) begin
                if (chk_done) begin
                    inflight = 0; ready_from = cyc + 2;
                    pend = 1; pend_cyc = cyc + 2;
                    p_side = m_side; p_count = m_count; p_code = m_code;
                    if (!chk_legal) begin
                        exp_p[cyc + 2] = 6'b000001; p_code = 2'b01;
                    end else begin
                        if (p_count != 10'h3FF) p_count = p_count + 10'd1;
                        if (chk_mate) begin
                            exp_p[cyc + 2] = m_cside ? 6'b001100 : 6'b110000;
                            over_from = cyc + 2;
                        end else if (chk_stale) begin
                            exp_p[cyc + 2] = 6'b000010;
                            over_from = cyc + 2;
                        end else begin
                            exp_p[cyc + 2] = m_cside ? 6'b001000 : 6'b100000;
                            p_side = ~m_side;
                        end
                    end
                end else if (cyc - start == TMO - 1) begin
                    inflight = 0; ready_from = cyc + 1;
                    exp_p[cyc + 1] = 6'b000001; m_code = 2'b10;
                end
            end
        end
        cyc = cyc + 1;
    end

    logic [5:0] pv;
    always @(negedge clk) begin
        if (run) begin
            pv = {WM, WC, BM, BC, SM, rej};
            chk("req_ready", int'(req_ready), int'(exp_ready(cyc)));
            chk("chk_valid", int'(chk_valid), int'(inflight));
            if (inflight) begin
                chk("chk_from", int'(chk_from), int'(m_from));
                chk("chk_to", int'(chk_to), int'(m_to));
                chk("chk_side", int'(chk_side), int'(m_cside));
            end
            chk("pulses", int'(pv), int'(exp_p[cyc]));
            chk("rej_code", int'(rej_code), int'(m_code));
            chk("side", int'(side), int'(m_side));
            chk("move_count", int'(move_count), int'(m_count));
            n_wm += int'(WM); n_wc += int'(WC); n_bm += int'(BM);
            n_bc += int'(BC); n_sm += int'(SM); n_rej += int'(rej);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [5:0] f, input logic [5:0] t);
        @(negedge clk); req_valid = 1'b1; req_from = f; req_to = t;
        @(negedge clk); req_valid = 1'b0; req_from = 6'($urandom); req_to = 6'($urandom);
    endtask

    task automatic wait_chk();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (chk_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("wait_chk_valid", 0, 1);
    endtask

    task automatic verdict(input logic l, input logic m, input logic s);
        chk_done = 1'b1; chk_legal = l; chk_mate = m; chk_stale = s;
        @(negedge clk);
        chk_done = 1'b0; chk_legal = 1'b0; chk_mate = 1'b0; chk_stale = 1'b0;
    endtask

    task automatic play(input logic [5:0] f, input logic [5:0] t, input int dly,
                        input logic l, input logic m, input logic s);
        send(f, t); wait_chk(); step(dly); verdict(l, m, s); step(2);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        step(2); reset = 1'b0;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_count", int'(move_count), 0);
        chk("rst_code", int'(rej_code), 0);

        send(12, 28); wait_chk();
        chk("t1_chk_side", int'(chk_side), 0);
        chk("t1_chk_from", int'(chk_from), 12);
        chk("t1_chk_to", int'(chk_to), 28);
        verdict(1, 0, 0); step(2);
        chk("t1_side", int'(side), 1);
        chk("t1_count", int'(move_count), 1);
        chk("t1_wm", n_wm, 1);

        play(52, 36, 2, 0, 0, 0);
        chk("t2_code", int'(rej_code), 1);
        chk("t2_side", int'(side), 1);
        chk("t2_count", int'(move_count), 1);
        chk("t2_bm", n_bm, 0);

        send(20, 20);
        chk("t3_rej", int'(rej), 1);
        chk("t3_code", int'(rej_code), 3);
        chk("t3_ready", int'(req_ready), 1);
        chk("t3_chk_valid", int'(chk_valid), 0);

        send(52, 36); wait_chk();
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (chk_valid) n++; else break;
        end
        chk("t4_check_len", n, 64);
        chk("t4_rej", int'(rej), 1);
        chk("t4_code", int'(rej_code), 2);

        send(52, 36); wait_chk(); step(TMO - 1); verdict(1, 0, 0); step(2);
        chk("t4b_side", int'(side), 0);
        chk("t4b_count", int'(move_count), 2);
        chk("t4b_bm", n_bm, 1);

        play(6, 22, 1, 1, 1, 0);
        chk("t5_wc", n_wc, 1);
        chk("t5_wm", n_wm, 2);
        chk("t5_count", int'(move_count), 3);
        chk("t5_ready", int'(req_ready), 0);
        send(1, 2); step(3);
        chk("t5_no_chk", int'(chk_valid), 0);
        chk("t5_rej", n_rej, 3);

        do_reset();
        chk("t6_ready", int'(req_ready), 1);
        chk("t6_count0", int'(move_count), 0);
        play(8, 16, 0, 1, 0, 0);
        play(48, 40, 0, 1, 0, 1);
        chk("t6_sm", n_sm, 1);
        chk("t6_bm", n_bm, 1);
        chk("t6_bc", n_bc, 0);
        chk("t6_count", int'(move_count), 2);
        chk("t6_ready_done", int'(req_ready), 0);

        do_reset();
        send(12, 28); wait_chk();
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        chk("t6r_chk_valid", int'(chk_valid), 0);
        verdict(1, 0, 0); step(3);
        chk("t6r_wm", n_wm, 3);
        chk("t6r_count", int'(move_count), 0);
        chk("t6r_side", int'(side), 0);
        chk("t6r_ready", int'(req_ready), 1);

        for (int i = 0; i < 1030; i++) play(1, 2, 0, 1, 0, 0);
        chk("sat_count", int'(move_count), 1023);
        chk("sat_side", int'(side), 0);

        play(1, 2, 0, 1, 1, 1);
        chk("prio_sm", n_sm, 1);
        chk("prio_wc", n_wc, 2);
        chk("prio_count", int'(move_count), 1023);
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
